// File: rtl/cpu6_inst_enc_pkg.sv
// Shared cpu6 instruction-kind codes, RV32I opcode/funct constants and the
// symbolic-request-to-word encoder used by the imem loader.
package cpu6_inst_enc_pkg;

    localparam int INSTKIND_SIZE = 4;

    typedef enum logic [INSTKIND_SIZE-1:0] {
        KIND_LW   = 4'd0,
        KIND_SW   = 4'd1,
        KIND_ADDI = 4'd2,
        KIND_ADD  = 4'd3,
        KIND_SUB  = 4'd4,
        KIND_BEQ  = 4'd5,
        KIND_BNE  = 4'd6,
        KIND_JALR = 4'd7,
        KIND_NOP  = 4'd8
    } inst_kind_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    typedef struct packed {
        logic [31:0] word;
        logic        legal;
        logic        misaligned;
    } enc_result_t;

    function automatic enc_result_t encode(
        input logic [INSTKIND_SIZE-1:0] kind,
        input logic [4:0]               rd,
        input logic [4:0]               rs1,
        input logic [4:0]               rs2,
        input logic [12:0]              imm
    );
        enc_result_t r;
        r.word       = '0;
        r.legal      = 1'b1;
        r.misaligned = 1'b0;
        case (inst_kind_e'(kind))
            KIND_LW:   r.word = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
            KIND_SW:   r.word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
            KIND_ADDI: r.word = {imm[11:0], rs1, F3_ADD, rd, OP_IMM};
            KIND_ADD:  r.word = {F7_ADD, rs2, rs1, F3_ADD, rd, OP_REG};
            KIND_SUB:  r.word = {F7_SUB, rs2, rs1, F3_ADD, rd, OP_REG};
            KIND_BEQ, KIND_BNE: begin
                // imm[0] has no slot in the B-type word, so an odd offset is simply dropped
                r.word = {imm[12], imm[10:5], rs2, rs1,
                          (inst_kind_e'(kind) == KIND_BNE) ? F3_BNE : F3_BEQ,
                          imm[4:1], imm[11], OP_BRANCH};
                r.misaligned = imm[0];
            end
            KIND_JALR: r.word = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
            KIND_NOP:  r.word = NOP_WORD;
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu6_inst_enc_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags; head is visible while not empty.
module cpu6_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/cpu6_inst_enc.sv
// RV32I instruction encoder: symbolic requests in, encoded words streamed
// into imem at consecutive word addresses starting from base_addr.
module cpu6_inst_enc
    import cpu6_inst_enc_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [INSTKIND_SIZE-1:0] req_kind,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rs1,
    input  logic [4:0]               req_rs2,
    input  logic [12:0]              req_imm,
    input  logic                     req_last,
    output logic                     imem_we,
    input  logic                     imem_ready,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    enc_state_e            state;
    enc_state_e            next_state;
    logic [ADDR_WIDTH-1:0] addr;
    enc_result_t           enc;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [31:0]           fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    assign enc       = encode(req_kind, req_rd, req_rs1, req_rs2, req_imm);
    assign req_ready = (state == ST_RUN) && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && enc.legal;
    assign imem_we   = ((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty;
    assign pop       = imem_we && imem_ready;
    assign imem_addr = addr;
    assign imem_wdata = fifo_empty ? '0 : fifo_head;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    cpu6_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (enc.word),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_RUN;
            ST_RUN:   if (accept && req_last) next_state = ST_DRAIN;
            // leave on the final pop itself so done lands right after the last write
            ST_DRAIN: if (fifo_empty || (pop && fifo_count == CNT_W'(1))) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            addr  <= '0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && start) begin
                addr <= base_addr;
                err  <= 1'b0;
            end else if (pop) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            if (accept && (!enc.legal || enc.misaligned)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu6_inst_enc.sv
// Self-checking bench for cpu6_inst_enc: directed ISA vectors plus random
// sessions checked every cycle against a queue-based behavioural model.
module tb_cpu6_inst_enc;
    localparam int ADDR_WIDTH = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int unsigned ADDR_SPAN = 1 << ADDR_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_kind;
    logic [4:0]            req_rd;
    logic [4:0]            req_rs1;
    logic [4:0]            req_rs2;
    logic [12:0]           req_imm;
    logic                  req_last;
    logic                  imem_we;
    logic                  imem_ready;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  busy;
    logic                  done;
    logic                  err;

    cpu6_inst_enc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cycle = 0;
    int unsigned n_acc = 0;
    bit          rand_ready = 1'b0;
    bit          fixed_ready = 1'b1;

    int unsigned log_addr[$];
    logic [31:0] log_data[$];
    int unsigned log_cyc[$];

    // model state
    bit          model_ok = 1'b0;
    bit          m_in_session = 1'b0;
    bit          m_taking = 1'b0;
    bit          m_done_now = 1'b0;
    bit          m_err = 1'b0;
    int unsigned m_addr = 0;
    logic [31:0] m_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RV32I field placement written as plain shifts of the ISA fields
    function automatic logic [31:0] model_word(input int unsigned kind, input int unsigned rd,
                                               input int unsigned rs1, input int unsigned rs2,
                                               input int unsigned imm);
        int unsigned w;
        int unsigned i12;
        i12 = imm & 32'hFFF;
        case (kind)
            0: w = (i12 << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            1: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 32'h1F) << 7) | 32'h23;
            2: w = (i12 << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
            3: w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
            4: w = (32'h20 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
            5, 6: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | ((kind == 6 ? 1 : 0) << 12) | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 1) << 7) | 32'h63;
            7: w = (i12 << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            default: w = 32'h13;
        endcase
        return w;
    endfunction

    always @(posedge clk) cycle++;

    initial begin
        imem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            imem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
        end
    end

    always @(negedge clk) begin
        bit exp_we;
        bit exp_ready;
        bit draining;
        bit legal;
        exp_we    = m_in_session && (m_q.size() != 0);
        exp_ready = m_in_session && m_taking && (m_q.size() < FIFO_DEPTH);
        if (imem_we && imem_ready) begin
            log_addr.push_back(32'(imem_addr));
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cycle);
        end
        if (model_ok) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("imem_we", 32'(imem_we), 32'(exp_we));
            check("busy", 32'(busy), 32'(m_in_session));
            check("done", 32'(done), 32'(m_done_now));
            check("err", 32'(err), 32'(m_err));
            if (exp_we && imem_we) begin
                check("imem_addr", 32'(imem_addr), m_addr);
                check("imem_wdata", imem_wdata, m_q[0]);
            end
        end
        if (reset) begin
            m_q.delete();
            m_in_session = 0;
            m_taking = 0;
            m_done_now = 0;
            m_err = 0;
            m_addr = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (m_done_now) begin
                m_done_now = 0;
                m_in_session = 0;
            end else if (!m_in_session) begin
                if (start) begin
                    m_in_session = 1;
                    m_taking = 1;
                    m_addr = 32'(base_addr);
                    m_err = 0;
                end
            end else begin
                draining = !m_taking;
                if (exp_we && imem_ready) begin
                    void'(m_q.pop_front());
                    m_addr = (m_addr + 1) % ADDR_SPAN;
                end
                if (exp_ready && req_valid) begin
                    legal = (req_kind <= 8);
                    if (legal)
                        m_q.push_back(model_word(32'(req_kind), 32'(req_rd), 32'(req_rs1),
                                                 32'(req_rs2), 32'(req_imm)));
                    if (!legal || ((req_kind == 5 || req_kind == 6) && req_imm[0]))
                        m_err = 1;
                    if (req_last) m_taking = 0;
                end
                if (draining && m_q.size() == 0) m_done_now = 1;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_start(input int unsigned base);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = ADDR_WIDTH'(base);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // call at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input int unsigned kind, input int unsigned rd, input int unsigned rs1,
                        input int unsigned rs2, input int unsigned imm, input bit last,
                        input bit stray_start);
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_kind = 4'(kind);
        req_rd = 5'(rd);
        req_rs1 = 5'(rs1);
        req_rs2 = 5'(rs2);
        req_imm = 13'(imm);
        req_last = last;
        start = stray_start;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: request kind %0d never accepted", kind);
        end else begin
            n_acc++;
        end
        req_valid = 1'b0;
        req_last = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(output int unsigned cyc);
        bit seen;
        seen = 0;
        cyc = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done) begin
                cyc = cycle;
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done pulse within budget");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned dc;
        int unsigned n0;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [31:0] exp_t2 [4];
        int unsigned len;
        int unsigned kind;

        exp_t2 = '{32'h0020A423, 32'h402081B3, 32'hFE208EE3, 32'h000280E7};
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        req_valid = 1'b0;
        req_kind = '0;
        req_rd = '0;
        req_rs1 = '0;
        req_rs2 = '0;
        req_imm = '0;
        req_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_addr", 32'(imem_addr), 0);
        reset = 1'b0;

        // single ADDI
        clear_log();
        do_start(12'h010);
        send(2, 1, 0, 0, 5, 1, 0);
        wait_done(dc);
        check("t1_count", log_data.size(), 1);
        if (log_data.size() >= 1) begin
            check("t1_addr", log_addr[0], 32'h010);
            check("t1_data", log_data[0], 32'h00500093);
            check("t1_done_lat", dc - log_cyc[0], 1);
        end
        check("t1_err", 32'(err), 0);

        // mixed formats
        clear_log();
        do_start(12'h020);
        send(1, 0, 1, 2, 8, 0, 0);
        send(4, 3, 1, 2, 0, 0, 0);
        send(5, 0, 1, 2, 13'h1FFC, 0, 0);
        send(7, 1, 5, 0, 0, 1, 0);
        wait_done(dc);
        check("t2_count", log_data.size(), 4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            check("t2_addr", log_addr[i], 32'h020 + i);
            check("t2_data", log_data[i], exp_t2[i]);
        end

        // backpressure from imem
        clear_log();
        fixed_ready = 1'b0;
        do_start(12'h040);
        n0 = n_acc;
        fork
            begin
                for (int i = 0; i < 6; i++) send(2, i + 1, 0, 0, i, i == 5, 0);
            end
        join_none
        repeat (12) @(negedge clk);
        check("t3_accepted", n_acc - n0, 4);
        check("t3_ready_low", 32'(req_ready), 0);
        check("t3_we_held", 32'(imem_we), 1);
        sa = 32'(imem_addr);
        sd = imem_wdata;
        @(negedge clk);
        check("t3_addr_stable", 32'(imem_addr), sa);
        check("t3_data_stable", imem_wdata, sd);
        fixed_ready = 1'b1;
        wait_done(dc);
        check("t3_count", log_data.size(), 6);
        for (int i = 0; i < 6 && i < log_data.size(); i++) begin
            check("t3_addr", log_addr[i], 32'h040 + i);
            check("t3_data", log_data[i], model_word(2, i + 1, 0, 0, i));
        end

        // address wrap, NOP ignores fields
        clear_log();
        do_start(12'hFFF);
        send(8, 7, 3, 9, 123, 0, 0);
        send(8, 0, 0, 0, 0, 1, 0);
        wait_done(dc);
        check("t4_count", log_data.size(), 2);
        if (log_data.size() == 2) begin
            check("t4_addr0", log_addr[0], 32'hFFF);
            check("t4_addr1", log_addr[1], 32'h000);
            check("t4_data0", log_data[0], 32'h00000013);
            check("t4_data1", log_data[1], 32'h00000013);
        end

        // illegal kind and odd branch offset
        clear_log();
        do_start(12'h080);
        send(12, 1, 2, 3, 4, 0, 0);
        send(5, 0, 1, 2, 3, 1, 0);
        wait_done(dc);
        check("t5_count", log_data.size(), 1);
        if (log_data.size() >= 1) check("t5_data", log_data[0], 32'h00208163);
        check("t5_err", 32'(err), 1);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", 32'(err), 1);

        // reset mid-session
        clear_log();
        fixed_ready = 1'b0;
        do_start(12'h0C0);
        check("t6_err_cleared", 32'(err), 0);
        send(3, 1, 2, 3, 0, 0, 0);
        send(4, 4, 5, 6, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_we", 32'(imem_we), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_ready", 32'(req_ready), 0);
        check("t6_no_writes", log_data.size(), 0);
        reset = 1'b0;
        fixed_ready = 1'b1;
        do_start(12'h100);
        send(2, 2, 2, 0, 12'h7FF, 1, 0);
        wait_done(dc);
        check("t6_count", log_data.size(), 1);
        if (log_data.size() >= 1) begin
            check("t6_addr", log_addr[0], 32'h100);
            check("t6_data", log_data[0], 32'h7FF10113);
        end

        // random sessions
        rand_ready = 1'b1;
        for (int s = 0; s < 40; s++) begin
            do_start($urandom_range(0, ADDR_SPAN - 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                kind = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                send(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 8191), j == len - 1, $urandom_range(0, 7) == 0);
            end
            wait_done(dc);
        end
        rand_ready = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu6_inst_enc.md
Name: cpu6_inst_enc

Overview:
- RV32I instruction encoder for cpu6; the inverse of the main decoder.
- Accepts symbolic instruction requests (kind, rd, rs1, rs2, imm) over a valid/ready handshake and encodes them into 32-bit RV32I words.
- Buffers encoded words in a small FIFO and streams them into instruction memory at consecutive word addresses.
- Used by the self-test/boot loader to build programs in imem without an external toolchain.

Parameters:
- ADDR_WIDTH, 12, imem word-address width.
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a load session at base_addr (honoured only in IDLE)
- base_addr  in  ADDR_WIDTH  first imem word address of the session
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_kind  in  4  instruction kind: 0 LW, 1 SW, 2 ADDI, 3 ADD, 4 SUB, 5 BEQ, 6 BNE, 7 JALR, 8 NOP; 9-15 illegal
- req_rd  in  5  destination register
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_imm  in  13  signed immediate; I/S kinds use [11:0], B kinds use [12:0] (byte offset)
- req_last  in  1  marks the final request of the session
- imem_we  out  1  write strobe; a write happens when imem_we & imem_ready
- imem_ready  in  1  memory accepts the write
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the session completes
- err  out  1  sticky error flag; cleared by reset or by an accepted start

Behaviour:
- Reset values:
  - state IDLE; FIFO empty; addr=0; err=0.
  - imem_we=0, req_ready=0, done=0, busy=0, imem_wdata=0.
- FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE -> RUN on start. addr<=base_addr, err<=0.
  - RUN -> DRAIN when a request with req_last=1 is accepted.
  - DRAIN -> DONE when the FIFO is empty. If the last pop and the transition coincide, DONE follows the pop cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- req_ready = (state==RUN) & !fifo_full. It is a registered-state function only and does not depend on req_valid.
- Encoding is combinational from the request fields. The encoded word is pushed on the accepting edge, so the earliest imem_we is the cycle after accept (latency 1).
- Encodings:
  - LW: opcode 0000011, f3 010.
  - SW: 0100011, f3 010, S-type immediate split.
  - ADDI: 0010011, f3 000.
  - ADD: 0110011, f3 000, f7 0000000.
  - SUB: as ADD with f7 0100000.
  - BEQ: 1100011, f3 000, B-type scramble imm[12|10:5] / imm[4:1|11].
  - BNE: as BEQ with f3 001.
  - JALR: 1100111, f3 000.
  - NOP: 0x00000013.
  - Fields not used by a kind are ignored (forced to 0 in the word, e.g. rs2 for I-type).
- Illegal kind: the request is consumed, no word is pushed, and err is set. A req_last on it still triggers DRAIN.
- B-kind with req_imm[0]=1: the word is pushed with bit0 dropped and err is set.
- Output side:
  - imem_we = (state in RUN or DRAIN) & !fifo_empty.
  - imem_wdata = FIFO head; imem_addr = addr.
  - On imem_we & imem_ready: pop the head and addr<=addr+1, modulo 2^ADDR_WIDTH (wraps silently).
- imem_we, addr and wdata are held stable while imem_ready=0.
- Simultaneous push and pop on a full FIFO is not permitted: req_ready is already low.
- Simultaneous push and pop when partially full: count is unchanged and order is preserved.
- reset mid-session: immediate return to IDLE, FIFO flushed, no further imem_we.

Decomposition:
- cpu6 shared defines, added to defines.v:
  - CPU6_INSTKIND_* codes and CPU6_INSTKIND_SIZE=4.
  - Opcode/funct3/funct7 constants reused by the decoder.
- Sub-module cpu6_sync_fifo: parameterised width/depth, push/pop/full/empty, synchronous reset.
- The encoder datapath stays inline as a combinational function of the request fields.

Test Plan:
- start with base_addr=0x010, then ADDI rd=1 rs1=0 imm=5 (last) -> one write: addr 0x010, data 0x00500093; done pulses one cycle later; err=0.
- SW rs1=1 rs2=2 imm=8; SUB rd=3 rs1=1 rs2=2; BEQ rs1=1 rs2=2 imm=-4; JALR rd=1 rs1=5 imm=0 (last) -> writes at consecutive addresses, data:
  - 0x0020A423
  - 0x402081B3
  - 0xFE208EE3
  - 0x000280E7
- imem_ready held 0 while 6 requests are offered -> exactly 4 accepted, then req_ready=0; imem_we/addr/wdata stable; on release all words are written in order with no loss or duplication.
- base_addr=0xFFF with two NOPs -> writes at 0xFFF then 0x000, both data 0x00000013.
- req_kind=12, then BEQ imm=3 (last) -> no word for the illegal kind; BEQ word written with bit0 dropped; err=1 and stays set until the next start.
- reset asserted after the 2nd accepted request of 4 -> next cycle imem_we=0, busy=0, req_ready=0; a fresh start then writes from its new base_addr.
